// File: rtl/pq_cmd_frontend_if.sv
// Insert/pop handshakes and heap-command bundle for pq_cmd_frontend.
// slave is the front-end's view; master is the surrounding logic's view.
interface pq_cmd_frontend_if #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned FIFO_DEPTH = 4
);
   localparam int unsigned CountWidth = $clog2(FIFO_DEPTH + 1);

   logic                  i_enq_valid;
   logic [DATA_WIDTH-1:0] i_enq_data;
   logic                  o_enq_ready;

   logic                  i_deq_ready;
   logic                  o_deq_valid;
   logic [DATA_WIDTH-1:0] o_deq_data;

   logic                  o_pq_wrt;
   logic                  o_pq_read;
   logic [DATA_WIDTH-1:0] o_pq_data;
   logic                  i_pq_full;
   logic                  i_pq_empty;
   logic [DATA_WIDTH-1:0] i_pq_data;

   logic [CountWidth-1:0] o_fifo_count;

   modport slave (
      input  i_enq_valid, i_enq_data, i_deq_ready, i_pq_full, i_pq_empty, i_pq_data,
      output o_enq_ready, o_deq_valid, o_deq_data, o_pq_wrt, o_pq_read, o_pq_data,
             o_fifo_count
   );

   modport master (
      output i_enq_valid, i_enq_data, i_deq_ready, i_pq_full, i_pq_empty, i_pq_data,
      input  o_enq_ready, o_deq_valid, o_deq_data, o_pq_wrt, o_pq_read, o_pq_data,
             o_fifo_count
   );
endinterface

// File: rtl/pq_cmd_frontend.sv
// Paced command front-end for the BRAM-tree max-priority queue: insert FIFO, one-entry pop
// response register, insert+pop fusion into replace. PQ_FE_BYPASS_EN enables the empty-heap bypass.
module pq_cmd_frontend #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned QUEUE_SIZE = 7,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned ISSUE_GAP  = 12
) (
   input logic              CLK,
   input logic              RSTn,
   pq_cmd_frontend_if.slave bus
);

   localparam int unsigned PtrWidth   = $clog2(FIFO_DEPTH);
   localparam int unsigned CountWidth = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned GapWidth   = $clog2(ISSUE_GAP);

   localparam logic [CountWidth-1:0] DepthCnt = CountWidth'(FIFO_DEPTH);
   localparam logic [GapWidth-1:0]   GapLoad  = GapWidth'(ISSUE_GAP - 1);

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || ISSUE_GAP < 2 ||
       QUEUE_SIZE < 1) begin : g_bad_params
      $error("pq_cmd_frontend: illegal parameter set");
   end

   typedef enum logic {
      StIdle,
      StHold
   } state_e;

   typedef enum logic [2:0] {
      ActNone,
      ActReplace,
      ActBypass,
      ActDequeue,
      ActInsert
   } act_e;

   // ---------------------------------------------------------------------------------------------
   // Insert FIFO
   // ---------------------------------------------------------------------------------------------
   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [PtrWidth-1:0]   rd_ptr_q, wr_ptr_q;
   logic [CountWidth-1:0] count_q, count_d;
   logic                  enq_ready_q;
   logic                  push, pop, fifo_nonempty;
   logic [DATA_WIDTH-1:0] head;

   // Zero is the heap's empty marker, so such keys are acknowledged but never stored.
   assign push          = bus.i_enq_valid && enq_ready_q && (bus.i_enq_data != '0);
   assign fifo_nonempty = (count_q != '0);
   assign head          = mem_q[rd_ptr_q];

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         enq_ready_q <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q     <= count_d;
         enq_ready_q <= (count_d < DepthCnt);
      end
   end

   always_ff @(posedge CLK) begin
      if (push) mem_q[wr_ptr_q] <= bus.i_enq_data;
   end

   // ---------------------------------------------------------------------------------------------
   // Command decode
   // ---------------------------------------------------------------------------------------------
   state_e                state_q, state_d;
   logic [GapWidth-1:0]   gap_q, gap_d;
   logic                  run_q;
   logic                  resp_valid_q, resp_valid_d;
   logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
   logic                  pop_pending, issue;
   act_e                  act;

   assign pop_pending = bus.i_deq_ready && !resp_valid_q;

   // run_q keeps every command output low while reset is held and on the release edge.
   always_comb begin
      act = ActNone;
      if (run_q && state_q == StIdle) begin
         if (pop_pending && fifo_nonempty && !bus.i_pq_empty) begin
            act = ActReplace;
`ifdef PQ_FE_BYPASS_EN
         end else if (pop_pending && bus.i_pq_empty && fifo_nonempty) begin
            act = ActBypass;
`endif
         end else if (pop_pending && !fifo_nonempty && !bus.i_pq_empty) begin
            act = ActDequeue;
         end else if (fifo_nonempty && !bus.i_pq_full && (!pop_pending || bus.i_pq_empty)) begin
            // A pop against an empty heap lets the insert go first when there is no bypass.
            act = ActInsert;
         end
      end
   end

   assign issue = (act == ActReplace) || (act == ActDequeue) || (act == ActInsert);
   assign pop   = (act == ActReplace) || (act == ActBypass) || (act == ActInsert);

   // ---------------------------------------------------------------------------------------------
   // Pacing FSM
   // ---------------------------------------------------------------------------------------------
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q <= StIdle;
         gap_q   <= '0;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         gap_q   <= gap_d;
         run_q   <= 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      gap_d   = gap_q;
      unique case (state_q)
         StIdle: begin
            if (issue) begin
               state_d = StHold;
               gap_d   = GapLoad;
            end
         end
         StHold: begin
            gap_d = gap_q - 1'b1;
            if (gap_d == '0) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      bus.o_pq_wrt  = 1'b0;
      bus.o_pq_read = 1'b0;
      bus.o_pq_data = '0;
      unique case (act)
         ActReplace: begin
            bus.o_pq_wrt  = 1'b1;
            bus.o_pq_read = 1'b1;
            bus.o_pq_data = head;
         end
         ActDequeue: bus.o_pq_read = 1'b1;
         ActInsert: begin
            bus.o_pq_wrt  = 1'b1;
            bus.o_pq_data = head;
         end
         default: ;
      endcase
   end

   // ---------------------------------------------------------------------------------------------
   // Pop response register
   // ---------------------------------------------------------------------------------------------
   always_comb begin
      resp_valid_d = resp_valid_q;
      resp_data_d  = resp_data_q;
      if (resp_valid_q && bus.i_deq_ready) begin
         resp_valid_d = 1'b0;
         resp_data_d  = '0;
      end else if (act == ActReplace || act == ActDequeue) begin
         resp_valid_d = 1'b1;
         resp_data_d  = bus.i_pq_data;
      end else if (act == ActBypass) begin
         resp_valid_d = 1'b1;
         resp_data_d  = head;
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
      end else begin
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
      end
   end

   assign bus.o_enq_ready  = enq_ready_q;
   assign bus.o_deq_valid  = resp_valid_q;
   assign bus.o_deq_data   = resp_data_q;
   assign bus.o_fifo_count = count_q;

endmodule

// File: tb/tb_pq_cmd_frontend.sv
// Bench for pq_cmd_frontend: emulates the heap and predicts every output from queue-based rules.
module tb_pq_cmd_frontend;
   localparam int unsigned DW  = 16;
   localparam int unsigned QS  = 7;
   localparam int unsigned FD  = 4;
   localparam int unsigned GAP = 4;
`ifdef PQ_FE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic CLK = 1'b0;
   logic RSTn;
   always #5 CLK = ~CLK;

   pq_cmd_frontend_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD)) bus ();

   pq_cmd_frontend #(
      .DATA_WIDTH(DW),
      .QUEUE_SIZE(QS),
      .FIFO_DEPTH(FD),
      .ISSUE_GAP (GAP)
   ) dut (
      .CLK (CLK),
      .RSTn(RSTn),
      .bus (bus)
   );

   // Reference state: insert buffer, emulated heap, response register, earliest next command.
   int m_fifo[$];
   int m_heap[$];
   bit m_rv;
   int m_rd;
   int cyc, next_ok;
   int nvec, nerr;

   // Observations from the latest step, used by the directed scenario checks.
   int obs_w, obs_r, obs_pd, obs_dv, obs_dd, obs_cnt, obs_rdy;
   int n_wrt, n_read, last_xfer;
   int wc[$];
   int wd[$];
   int pace_keys[3] = '{5, 9, 3};

   task automatic chk(input string tag, input int obs, input int exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int heap_max();
      int m = 0;
      foreach (m_heap[i]) if (m_heap[i] > m) m = m_heap[i];
      return m;
   endfunction

   function automatic void heap_pop_max();
      int idx = 0;
      foreach (m_heap[i]) if (m_heap[i] > m_heap[idx]) idx = i;
      m_heap.delete(idx);
   endfunction

   task automatic step(input bit ev, input int ed, input bit dr);
      bit pend, fn, idle, full, empty, ex_w, ex_r, ex_rdy;
      int key, head, act, ex_d;
      @(negedge CLK);
      key   = ed & 32'hFFFF;
      full  = (m_heap.size() >= QS);
      empty = (m_heap.size() == 0);
      bus.i_enq_valid = ev;
      bus.i_enq_data  = key[DW-1:0];
      bus.i_deq_ready = dr;
      bus.i_pq_full   = full;
      bus.i_pq_empty  = empty;
      bus.i_pq_data   = DW'(heap_max());
      #1;
      fn     = (m_fifo.size() != 0);
      head   = fn ? m_fifo[0] : 0;
      pend   = dr && !m_rv;
      idle   = (cyc >= next_ok);
      ex_rdy = (m_fifo.size() < FD);
      // 0 none, 1 replace, 2 bypass, 3 dequeue, 4 insert
      act = 0;
      if (idle) begin
         if (pend && fn && !empty) act = 1;
         else if (BYP && pend && empty && fn) act = 2;
         else if (pend && !fn && !empty) act = 3;
         else if (fn && !full && (!pend || empty)) act = 4;
      end
      ex_w = (act == 1) || (act == 4);
      ex_r = (act == 1) || (act == 3);
      ex_d = ex_w ? head : 0;

      obs_w   = int'(bus.o_pq_wrt);
      obs_r   = int'(bus.o_pq_read);
      obs_pd  = int'(bus.o_pq_data);
      obs_dv  = int'(bus.o_deq_valid);
      obs_dd  = int'(bus.o_deq_data);
      obs_cnt = int'(bus.o_fifo_count);
      obs_rdy = int'(bus.o_enq_ready);

      chk("enq_ready", obs_rdy, int'(ex_rdy));
      chk("fifo_count", obs_cnt, m_fifo.size());
      chk("deq_valid", obs_dv, int'(m_rv));
      if (m_rv) chk("deq_data", obs_dd, m_rd);
      chk("pq_wrt", obs_w, int'(ex_w));
      chk("pq_read", obs_r, int'(ex_r));
      chk("pq_data", obs_pd, ex_d);

      if (obs_w != 0) begin
         n_wrt++;
         wc.push_back(cyc);
         wd.push_back(obs_pd);
      end
      if (obs_r != 0) n_read++;
      if (obs_dv != 0 && dr) last_xfer = obs_dd;

      if (m_rv && dr) m_rv = 1'b0;
      case (act)
         1: begin
            m_rd = heap_max();
            heap_pop_max();
            m_heap.push_back(head);
            void'(m_fifo.pop_front());
            m_rv = 1'b1;
         end
         2: begin
            m_rd = head;
            void'(m_fifo.pop_front());
            m_rv = 1'b1;
         end
         3: begin
            m_rd = heap_max();
            heap_pop_max();
            m_rv = 1'b1;
         end
         4: begin
            m_heap.push_back(head);
            void'(m_fifo.pop_front());
         end
         default: ;
      endcase
      if (act == 1 || act == 3 || act == 4) next_ok = cyc + GAP;
      if (ev && ex_rdy && key != 0) m_fifo.push_back(key);
      cyc++;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_enq_ready"}, int'(bus.o_enq_ready), 0);
      chk({tag, "_deq_valid"}, int'(bus.o_deq_valid), 0);
      chk({tag, "_deq_data"}, int'(bus.o_deq_data), 0);
      chk({tag, "_pq_wrt"}, int'(bus.o_pq_wrt), 0);
      chk({tag, "_pq_read"}, int'(bus.o_pq_read), 0);
      chk({tag, "_pq_data"}, int'(bus.o_pq_data), 0);
      chk({tag, "_fifo_count"}, int'(bus.o_fifo_count), 0);
   endtask

   task automatic do_reset();
      @(negedge CLK);
      bus.i_enq_valid = 1'b0;
      bus.i_deq_ready = 1'b0;
      #2 RSTn = 1'b0;
      #1 check_all_zero("rst");
      m_fifo.delete();
      m_rv    = 1'b0;
      next_ok = 0;
      @(negedge CLK);
      RSTn = 1'b1;
   endtask

   initial begin
      nvec = 0; nerr = 0; cyc = 0; next_ok = 0; m_rv = 1'b0; m_rd = 0;
      n_wrt = 0; n_read = 0; last_xfer = 0;
      RSTn = 1'b0;
      bus.i_enq_valid = 1'b0;
      bus.i_enq_data  = '0;
      bus.i_deq_ready = 1'b0;
      bus.i_pq_full   = 1'b0;
      bus.i_pq_empty  = 1'b1;
      bus.i_pq_data   = '0;
      #2 check_all_zero("init");
      @(negedge CLK);
      RSTn = 1'b1;

      // Pacing: three back-to-back keys into an empty heap.
      wc.delete(); wd.delete();
      step(1'b1, 5, 1'b0);
      step(1'b1, 9, 1'b0);
      step(1'b1, 3, 1'b0);
      for (int i = 0; i < 12; i++) step(1'b0, 0, 1'b0);
      chk("pace_pulses", wc.size(), 3);
      for (int i = 0; i < wc.size() && i < 3; i++) begin
         chk("pace_key", wd[i], pace_keys[i]);
         if (i > 0) chk("pace_gap", wc[i] - wc[i-1], GAP);
      end
      chk("pace_drain", obs_cnt, 0);

      // Replace: full heap with root 9, key 7 waiting in the FIFO.
      m_heap = {9, 1, 2, 3, 4, 5, 6};
      step(1'b1, 7, 1'b0);
      step(1'b0, 0, 1'b0);
      step(1'b0, 0, 1'b1);
      chk("rep_wrt", obs_w, 1);
      chk("rep_read", obs_r, 1);
      chk("rep_key", obs_pd, 7);
      step(1'b0, 0, 1'b1);
      chk("rep_dv", obs_dv, 1);
      chk("rep_dd", obs_dd, 9);
      chk("rep_cnt", obs_cnt, 0);

      // Bypass (or insert-then-dequeue when bypass is compiled out) against an empty heap.
      m_heap.delete();
      for (int i = 0; i < 5; i++) step(1'b0, 0, 1'b0);
      n_wrt = 0; n_read = 0; last_xfer = 0;
      step(1'b1, 42, 1'b0);
      for (int i = 0; i < 8; i++) step(1'b0, 0, 1'b1);
      chk("byp_xfer", last_xfer, 42);
      chk("byp_wrt", n_wrt, BYP ? 0 : 1);
      chk("byp_read", n_read, BYP ? 0 : 1);

      // Zero key and FIFO fill against a full heap.
      m_heap = {50, 1, 2, 3, 4, 5, 6};
      for (int i = 0; i < 5; i++) step(1'b0, 0, 1'b0);
      n_wrt = 0;
      step(1'b1, 11, 1'b0);
      step(1'b1, 0, 1'b0);
      step(1'b1, 12, 1'b0);
      chk("zero_cnt", obs_cnt, 1);
      step(1'b1, 13, 1'b0);
      step(1'b1, 14, 1'b0);
      step(1'b1, 15, 1'b0);
      step(1'b0, 0, 1'b0);
      chk("full_cnt", obs_cnt, 4);
      chk("full_rdy", obs_rdy, 0);
      chk("full_nowrt", n_wrt, 0);

      // Backpressure: capture the root, then hold it with the consumer stalled.
      step(1'b0, 0, 1'b1);
      n_read = 0;
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 0, 1'b0);
         chk("bp_valid", obs_dv, 1);
         chk("bp_data", obs_dd, 50);
      end
      chk("bp_noread", n_read, 0);
      step(1'b0, 0, 1'b1);

      // Reset while in HOLD with two keys buffered.
      do_reset();
      m_heap.delete();
      step(1'b1, 21, 1'b0);
      step(1'b1, 22, 1'b0);
      step(1'b1, 23, 1'b0);
      do_reset();
      n_wrt = 0; n_read = 0;
      for (int i = 0; i < 6; i++) step(1'b0, 0, 1'b0);
      chk("post_rst_idle", n_wrt + n_read, 0);

      // Random traffic against the reference model.
      for (int i = 0; i < 600; i++) begin
         int k;
         k = ($urandom % 8 == 0) ? 0 : int'($urandom_range(65535, 1));
         step(bit'($urandom % 2), k, bit'($urandom % 3 == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
